// File: rtl/disp_pkg.sv
// Shared display definitions: glyph codes and the glyph-to-segment table used by
// the scanner and the text generators.
package disp_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NDIG    = 4;

    localparam logic [GLYPH_W-1:0] GLYPH_0 = 5'd0,  GLYPH_1 = 5'd1,  GLYPH_2 = 5'd2,  GLYPH_3 = 5'd3;
    localparam logic [GLYPH_W-1:0] GLYPH_4 = 5'd4,  GLYPH_5 = 5'd5,  GLYPH_6 = 5'd6,  GLYPH_7 = 5'd7;
    localparam logic [GLYPH_W-1:0] GLYPH_8 = 5'd8,  GLYPH_9 = 5'd9,  GLYPH_A = 5'd10, GLYPH_B = 5'd11;
    localparam logic [GLYPH_W-1:0] GLYPH_C = 5'd12, GLYPH_D = 5'd13, GLYPH_E = 5'd14, GLYPH_F = 5'd15;
    localparam logic [GLYPH_W-1:0] GLYPH_H = 5'd16, GLYPH_J = 5'd17, GLYPH_L = 5'd18, GLYPH_N = 5'd19;
    localparam logic [GLYPH_W-1:0] GLYPH_P = 5'd20, GLYPH_O_LC = 5'd21, GLYPH_R = 5'd22, GLYPH_T = 5'd23;
    localparam logic [GLYPH_W-1:0] GLYPH_U = 5'd24, GLYPH_Y = 5'd25, GLYPH_DASH = 5'd26, GLYPH_UNDER = 5'd27;
    localparam logic [GLYPH_W-1:0] GLYPH_I = 5'd28, GLYPH_G = 5'd29, GLYPH_U_LC = 5'd30, GLYPH_BLANK = 5'd31;
    localparam logic [GLYPH_W-1:0] GLYPH_S = GLYPH_5, GLYPH_O = GLYPH_0;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for a glyph code.
    function automatic logic [SEG_W-1:0] glyph2seg(input logic [GLYPH_W-1:0] g);
        logic [SEG_W-1:0] s;
        case (g)
            5'd0:  s = 7'h40;  5'd1:  s = 7'h79;  5'd2:  s = 7'h24;  5'd3:  s = 7'h30;
            5'd4:  s = 7'h19;  5'd5:  s = 7'h12;  5'd6:  s = 7'h02;  5'd7:  s = 7'h78;
            5'd8:  s = 7'h00;  5'd9:  s = 7'h10;  5'd10: s = 7'h08;  5'd11: s = 7'h03;
            5'd12: s = 7'h46;  5'd13: s = 7'h21;  5'd14: s = 7'h06;  5'd15: s = 7'h0E;
            5'd16: s = 7'h09;  5'd17: s = 7'h61;  5'd18: s = 7'h47;  5'd19: s = 7'h2B;
            5'd20: s = 7'h0C;  5'd21: s = 7'h23;  5'd22: s = 7'h2F;  5'd23: s = 7'h07;
            5'd24: s = 7'h41;  5'd25: s = 7'h11;  5'd26: s = 7'h3F;  5'd27: s = 7'h77;
            5'd28: s = 7'h7B;  5'd29: s = 7'h42;  5'd30: s = 7'h63;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/glyph_decode.sv
// Pure combinational glyph code to active-low segment decoder.
module glyph_decode
    import disp_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph_i,
    output logic [SEG_W-1:0]   seg_c
);

    assign seg_c = glyph2seg(glyph_i);

endmodule

// File: rtl/seg_scan.sv
// Four-digit common-anode scanner: per-frame input latch, glyph decode, decimal
// points and per-digit blink, all outputs registered.
module seg_scan
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [19:0] code,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [19:0]      fcode_q, fcode_d;
    logic [3:0]       fdp_q, fdp_d;
    logic [3:0]       fblink_q, fblink_d;
    logic             fvld_q, fvld_d;
    logic [BLK_W-1:0] bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;

    logic             wrap_c, latch_c, lit_c;
    logic [4:0]       glyph_c;
    logic [6:0]       dec_seg_c;

    assign wrap_c  = en && (pre_q == PRE_W'(SCAN_DIV - 1));
    assign latch_c = wrap_c && (idx_q == 2'd3);
    // Nothing lights until the first frame has been latched.
    assign lit_c   = fvld_q && !(phase_q && fblink_q[idx_q]);

    always_comb begin
        case (idx_q)
            2'd0:    glyph_c = fcode_q[4:0];
            2'd1:    glyph_c = fcode_q[9:5];
            2'd2:    glyph_c = fcode_q[14:10];
            default: glyph_c = fcode_q[19:15];
        endcase
    end

    glyph_decode u_dec (
        .glyph_i (glyph_c),
        .seg_c   (dec_seg_c)
    );

    always_comb begin
        pre_d    = pre_q;
        idx_d    = idx_q;
        fcode_d  = fcode_q;
        fdp_d    = fdp_q;
        fblink_d = fblink_q;
        fvld_d   = fvld_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        an_d     = 4'hF;
        seg_d    = SEG_BLANK;
        dp_d     = 1'b1;
        tick_d   = latch_c;

        if (en) begin
            pre_d = wrap_c ? '0 : pre_q + PRE_W'(1);
            if (wrap_c) idx_d = idx_q + 2'd1;
            if (lit_c) begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = dec_seg_c;
                dp_d  = ~fdp_q[idx_q];
            end
        end

        // Frame boundary: capture inputs and advance the blink frame counter.
        if (latch_c) begin
            fcode_d  = code;
            fdp_d    = dp_in;
            fblink_d = blink;
            fvld_d   = 1'b1;
            if (bcnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            idx_q    <= '0;
            fcode_q  <= {NDIG{GLYPH_BLANK}};
            fdp_q    <= '0;
            fblink_q <= '0;
            fvld_q   <= 1'b0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            fcode_q  <= fcode_d;
            fdp_q    <= fdp_d;
            fblink_q <= fblink_d;
            fvld_q   <= fvld_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: fixed slot vectors, directed corner sequences and random
// stimulus against a frame-level reference model.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [19:0] code = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .code       (code),
        .dp_in      (dp_in),
        .blink      (blink),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Lit segments (active-high, bit0=a .. bit6=g) per glyph code.
    logic [6:0] lit_tab [32];

    // Model state: enabled cycles since reset, number of frames latched, latched inputs.
    int          m_n;
    int          m_l;
    logic [19:0] m_code;
    logic [3:0]  m_dp;
    logic [3:0]  m_blink;

    typedef struct {
        logic [19:0] code;
        logic [3:0]  dpin;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_l = 0;
        m_code = {4{5'd31}};
        m_dp = '0;
        m_blink = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp_tick", 32'({dp, frame_tick}), 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: predict registered outputs from pre-edge model state, then advance model.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_tick;
        int         idx, ph, g;
        @(posedge clk);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        if (en) begin
            idx = (m_n / SD) % 4;
            ph  = (m_l / BF) % 2;
            if (m_l > 0 && !(ph == 1 && m_blink[idx])) begin
                e_an  = ~(4'b0001 << idx);
                g     = int'((m_code >> (5 * idx)) & 20'h1F);
                e_seg = ~lit_tab[g];
                e_dp  = ~m_dp[idx];
            end
            e_tick = ((m_n % (4 * SD)) == 4 * SD - 1);
            m_n++;
            if (m_n % (4 * SD) == 0) begin
                m_l++;
                m_code  = code;
                m_dp    = dp_in;
                m_blink = blink;
            end
        end
        @(negedge clk);
        chk("cycle", 32'({an, seg, dp, frame_tick}), 32'({e_an, e_seg, e_dp, e_tick}));
    endtask

    initial begin
        lit_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                    7'h76, 7'h1E, 7'h38, 7'h54, 7'h73, 7'h5C, 7'h50, 7'h78,
                    7'h3E, 7'h6E, 7'h40, 7'h08, 7'h04, 7'h3D, 7'h1C, 7'h00};

        vt[0] = '{{5'd16, 5'd14, 5'd18, 5'd20}, 4'b0100, 0, 4'b1110, 7'h0C, 1'b1};
        vt[1] = '{{5'd16, 5'd14, 5'd18, 5'd20}, 4'b0100, 1, 4'b1101, 7'h47, 1'b1};
        vt[2] = '{{5'd16, 5'd14, 5'd18, 5'd20}, 4'b0100, 2, 4'b1011, 7'h06, 1'b0};
        vt[3] = '{{5'd16, 5'd14, 5'd18, 5'd20}, 4'b0100, 3, 4'b0111, 7'h09, 1'b1};
        vt[4] = '{{5'd31, 5'd12, 5'd18, 5'd10}, 4'b0000, 3, 4'b0111, 7'h7F, 1'b1};
        vt[5] = '{{5'd31, 5'd12, 5'd18, 5'd10}, 4'b0000, 2, 4'b1011, 7'h46, 1'b1};
        vt[6] = '{{5'd31, 5'd12, 5'd18, 5'd10}, 4'b0000, 0, 4'b1110, 7'h08, 1'b1};
        vt[7] = '{{5'd0, 5'd5, 5'd8, 5'd27}, 4'b1111, 0, 4'b1110, 7'h77, 1'b0};
        vt[8] = '{{5'd0, 5'd5, 5'd8, 5'd27}, 4'b1111, 1, 4'b1101, 7'h00, 1'b0};
        vt[9] = '{{5'd0, 5'd5, 5'd8, 5'd27}, 4'b1111, 3, 4'b0111, 7'h40, 1'b0};

        // Fixed vectors: first frame latched at edge 16, slot s shown from edge 17+4s.
        for (int i = 0; i < 10; i++) begin
            en = 1'b1; blink = '0;
            do_reset();
            code = vt[i].code;
            dp_in = vt[i].dpin;
            repeat (16 + 4 * vt[i].slot + 2) step();
            chk("vec_an", 32'(an), 32'(vt[i].an));
            chk("vec_seg", 32'(seg), 32'(vt[i].seg));
            chk("vec_dp", 32'(dp), 32'(vt[i].dp));
        end

        // HELP, then mid-frame change that must wait for the next frame boundary.
        do_reset();
        code = {5'd16, 5'd14, 5'd18, 5'd20};
        dp_in = 4'b0100;
        repeat (16) step();
        chk("tick16", 32'(frame_tick), 32'h1);
        repeat (10) step();
        code = {5'd31, 5'd12, 5'd18, 5'd10};
        repeat (2) step();
        chk("still_E", 32'({an, seg}), 32'({4'b1011, 7'h06}));
        repeat (20) step();

        // Blink on digit 0 over several frames.
        blink = 4'b0001;
        repeat (160) step();

        // Enable dropped mid-slot for 10 cycles.
        repeat (6) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (40) step();

        // Asynchronous reset between clock edges while a digit is lit.
        blink = '0;
        repeat (70) step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp_tick", 32'({dp, frame_tick}), 32'b10);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();

        // Random stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) code = 20'($urandom);
            if ($urandom_range(7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(15) == 0) blink = 4'($urandom);
            en = ($urandom_range(15) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
